// File: rtl/design_params.sv
// -----------------------------------------------------------------------------
// design_params
// Shared definitions for the cache request queue:
//   - req_op_e     : CPU/controller op encoding (NO_OP, READ, WRITE, reserved)
//   - req_entry_t  : packed queue entry {op, id, addr, wdata}. It is sized for
//                    the default widths. The top packs entries in the same field
//                    order using its own parameters, so a non-default build
//                    keeps this layout.
//   - is_mem_op()  : true for ops that occupy a queue slot and consume an ID
// -----------------------------------------------------------------------------
package design_params;

    localparam int DEF_ADDRESS_WIDTH = 32;
    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_REQ_ID        = 3;

    typedef enum logic [1:0] {
        OP_NO_OP = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_RSVD  = 2'b11
    } req_op_e;

    typedef struct packed {
        req_op_e                      op;
        logic [DEF_REQ_ID-1:0]        id;
        logic [DEF_ADDRESS_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0]    wdata;
    } req_entry_t;

    function automatic logic is_mem_op(input logic [1:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/cache_req_queue_mem.sv
// -----------------------------------------------------------------------------
// req_fifo_mem
// Entry storage for cache_req_queue: DEPTH x WIDTH register array with one
// synchronous write port and one asynchronous (combinational) read port.
// The array has no reset. The top never shows an entry unless its count says
// the slot holds valid data.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write slot index
//   wr_data  in   entry to store
//   rd_addr  in   read slot index (head pointer)
//   rd_data  out  entry at rd_addr, same cycle
// -----------------------------------------------------------------------------
module req_fifo_mem
    import design_params::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = $bits(req_entry_t)
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cache_req_queue.sv
// -----------------------------------------------------------------------------
// cache_req_queue
// In-order request queue between a CPU and a cache controller. READ and WRITE
// requests get a rolling ID and are buffered in a DEPTH-entry FIFO. The
// controller completes IDs strictly in issue order. NO_OP and reserved ops are
// accepted and dropped.
//
// Optional feature: define CACHE_REQ_QUEUE_BYPASS_EN to let a request that
// arrives at an empty queue, while the controller is ready, go straight to
// ctrl_* in the same cycle without being stored. Without the macro, every
// request is stored first and appears on ctrl_* one cycle after it is pushed.
//
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   cpu_valid/cpu_ready           CPU request handshake
//   cpu_op/cpu_addr/cpu_wdata     CPU request payload
//   ctrl_valid/ctrl_ready         controller handshake (head of queue)
//   ctrl_op/id/addr/wdata         head request payload (0 when empty)
//   cpl_valid/cpl_id              in-order completion from the controller
//   count                         number of queued entries
//   outstanding                   issued-but-uncompleted IDs
//   err_cpl                       sticky bad-completion flag
// -----------------------------------------------------------------------------
module cache_req_queue
    import design_params::*;
#(
    parameter int DEPTH         = 4,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int REQ_ID        = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cpu_valid,
    output logic                     cpu_ready,
    input  logic [1:0]               cpu_op,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    output logic                     ctrl_valid,
    input  logic                     ctrl_ready,
    output logic [1:0]               ctrl_op,
    output logic [REQ_ID-1:0]        ctrl_id,
    output logic [ADDRESS_WIDTH-1:0] ctrl_addr,
    output logic [DATA_WIDTH-1:0]    ctrl_wdata,
    input  logic                     cpl_valid,
    input  logic [REQ_ID-1:0]        cpl_id,
    output logic [$clog2(DEPTH):0]   count,
    output logic [REQ_ID:0]          outstanding,
    output logic                     err_cpl
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 2 + REQ_ID + ADDRESS_WIDTH + DATA_WIDTH;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [REQ_ID:0]  MAX_OUT    = {1'b1, {REQ_ID{1'b0}}};

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;
    logic [REQ_ID-1:0]  next_id;
    logic [REQ_ID-1:0]  oldest_id;
    logic [REQ_ID:0]    outstanding_q;
    logic               err_q;

    logic               push_acc;
    logic               mem_req;
    logic               bypass;
    logic               store;
    logic               pop;
    logic               queue_nonempty;
    logic               cpl_ok;
    logic               cpl_err;
    logic [ENTRY_W-1:0] new_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic [ENTRY_W-1:0] ctrl_entry;

    // Ready depends only on registered state, so there is no path from
    // ctrl_ready. A full queue blocks a push even in a cycle that pops.
    // The reset_n term holds ready low for the whole reset.
    assign cpu_ready = reset_n && (count_q < FULL_COUNT) && (outstanding_q < MAX_OUT);

    assign push_acc       = cpu_valid & cpu_ready;
    assign mem_req        = push_acc & is_mem_op(cpu_op);
    assign queue_nonempty = (count_q != '0);
    assign new_entry      = {cpu_op, next_id, cpu_addr, cpu_wdata};

`ifdef CACHE_REQ_QUEUE_BYPASS_EN
    assign bypass = mem_req & ~queue_nonempty & ctrl_ready;
`else
    assign bypass = 1'b0;
`endif

    assign store = mem_req & ~bypass;
    assign pop   = queue_nonempty & ctrl_ready;

    // Completions must arrive in issue order. A completion for the wrong ID,
    // or with nothing outstanding, is flagged and otherwise ignored.
    assign cpl_ok  = cpl_valid && (outstanding_q != '0) && (cpl_id == oldest_id);
    assign cpl_err = cpl_valid & ~cpl_ok;

    req_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (store),
        .wr_addr (wr_ptr),
        .wr_data (new_entry),
        .rd_addr (rd_ptr),
        .rd_data (head_entry)
    );

    // Storage is not reset, so the head is masked to zero when the queue is empty.
    always_comb begin
        ctrl_entry = '0;
        if (queue_nonempty) begin
            ctrl_entry = head_entry;
        end else if (bypass) begin
            ctrl_entry = new_entry;
        end
    end

    assign ctrl_valid = queue_nonempty | bypass;
    assign {ctrl_op, ctrl_id, ctrl_addr, ctrl_wdata} = ctrl_entry;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count_q       <= '0;
            next_id       <= '0;
            oldest_id     <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({store, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            if (mem_req) begin
                next_id <= next_id + 1'b1;
            end
            if (cpl_ok) begin
                oldest_id <= oldest_id + 1'b1;
            end
            case ({mem_req, cpl_ok})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: outstanding_q <= outstanding_q;
            endcase

            if (cpl_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign count       = count_q;
    assign outstanding = outstanding_q;
    assign err_cpl     = err_q;

endmodule

// File: tb/tb_cache_req_queue.sv
module tb_cache_req_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int IDW   = 3;

    localparam logic [1:0] T_NOP   = 2'b00;
    localparam logic [1:0] T_READ  = 2'b01;
    localparam logic [1:0] T_WRITE = 2'b10;
    localparam logic [1:0] T_RSVD  = 2'b11;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     cpu_valid;
    logic                     cpu_ready;
    logic [1:0]               cpu_op;
    logic [AW-1:0]            cpu_addr;
    logic [DW-1:0]            cpu_wdata;
    logic                     ctrl_valid;
    logic                     ctrl_ready;
    logic [1:0]               ctrl_op;
    logic [IDW-1:0]           ctrl_id;
    logic [AW-1:0]            ctrl_addr;
    logic [DW-1:0]            ctrl_wdata;
    logic                     cpl_valid;
    logic [IDW-1:0]           cpl_id;
    logic [$clog2(DEPTH):0]   count;
    logic [IDW:0]             outstanding;
    logic                     err_cpl;

    typedef struct packed {
        logic [1:0]     op;
        logic [IDW-1:0] id;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wdata;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    cache_req_queue #(
        .DEPTH         (DEPTH),
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .REQ_ID        (IDW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_valid   (cpu_valid),
        .cpu_ready   (cpu_ready),
        .cpu_op      (cpu_op),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .ctrl_valid  (ctrl_valid),
        .ctrl_ready  (ctrl_ready),
        .ctrl_op     (ctrl_op),
        .ctrl_id     (ctrl_id),
        .ctrl_addr   (ctrl_addr),
        .ctrl_wdata  (ctrl_wdata),
        .cpl_valid   (cpl_valid),
        .cpl_id      (cpl_id),
        .count       (count),
        .outstanding (outstanding),
        .err_cpl     (err_cpl)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every controller-side transfer is matched against
    // the oldest expected request.
    always @(negedge clk) begin : monitor
        exp_t got;
        exp_t want;
        if (reset_n && ctrl_valid && ctrl_ready) begin
            got = {ctrl_op, ctrl_id, ctrl_addr, ctrl_wdata};
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got op=%0d id=%0d addr=0x%0h wdata=0x%0h, required no transfer",
                         got.op, got.id, got.addr, got.wdata);
            end else begin
                want = sb.pop_front();
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL sb_entry: got op=%0d id=%0d addr=0x%0h wdata=0x%0h, required op=%0d id=%0d addr=0x%0h wdata=0x%0h",
                             got.op, got.id, got.addr, got.wdata, want.op, want.id, want.addr, want.wdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle push that the bench expects to be accepted.
    task automatic push(input logic [1:0] op, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [IDW-1:0] id);
        cpu_valid = 1'b1;
        cpu_op    = op;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        #1;
        check("push_ready", cpu_ready, 1);
        if (op == T_READ || op == T_WRITE) begin
            sb.push_back({op, id, addr, wdata});
        end
        @(posedge clk);
        #1;
        cpu_valid = 1'b0;
        cpu_op    = T_NOP;
    endtask

    task automatic complete(input logic [IDW-1:0] id);
        cpl_valid = 1'b1;
        cpl_id    = id;
        tick();
        cpl_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        ctrl_ready = 1'b1;
        for (int i = 0; i < 20 && count != 0; i++) begin
            tick();
        end
        check(name, count, 0);
        ctrl_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sb.delete();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        reset_n    = 1'b0;
        cpu_valid  = 1'b0;
        cpu_op     = T_NOP;
        cpu_addr   = '0;
        cpu_wdata  = '0;
        ctrl_ready = 1'b0;
        cpl_valid  = 1'b0;
        cpl_id     = '0;

        // Reset state
        tick();
        tick();
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_ctrl_valid", ctrl_valid, 0);
        check("rst_count", count, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_err", err_cpl, 0);
        reset_n = 1'b1;
        #1;
        check("rel_cpu_ready", cpu_ready, 1);
        tick();

        // First READ shows up one cycle after push with ID 0
        push(T_READ, 32'h100, 32'h0, 3'd0);
        check("b_ctrl_valid", ctrl_valid, 1);
        check("b_ctrl_id", ctrl_id, 0);
        check("b_ctrl_addr", ctrl_addr, 32'h100);
        check("b_count", count, 1);
        check("b_outstanding", outstanding, 1);
        drain("b_drain");
        complete(3'd0);
        check("b_cpl_outstanding", outstanding, 0);
        check("b_cpl_err", err_cpl, 0);

        // NO_OP and reserved ops are consumed without effect
        push(T_NOP, 32'h111, 32'h22, 3'd0);
        check("c_nop_count", count, 0);
        check("c_nop_ctrl_valid", ctrl_valid, 0);
        check("c_nop_outstanding", outstanding, 0);
        push(T_RSVD, 32'h113, 32'h33, 3'd0);
        check("c_rsvd_count", count, 0);
        check("c_rsvd_outstanding", outstanding, 0);
        push(T_READ, 32'h180, 32'h0, 3'd1);
        check("c_next_id", ctrl_id, 1);
        drain("c_drain");

        // Completion with nothing outstanding
        complete(3'd1);
        check("d_outstanding0", outstanding, 0);
        check("d_err_clear", err_cpl, 0);
        complete(3'd2);
        check("d_err_set", err_cpl, 1);
        check("d_outstanding_hold", outstanding, 0);

        // Reset mid-operation discards queued entries
        push(T_READ, 32'h300, 32'h0, 3'd2);
        push(T_WRITE, 32'h304, 32'h55, 3'd3);
        check("e_count_pre", count, 2);
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("e_count", count, 0);
        check("e_ctrl_valid", ctrl_valid, 0);
        check("e_ctrl_addr", ctrl_addr, 0);
        check("e_ctrl_wdata", ctrl_wdata, 0);
        check("e_outstanding", outstanding, 0);
        check("e_err", err_cpl, 0);
        check("e_cpu_ready", cpu_ready, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Fill to DEPTH with the controller stalled
        push(T_WRITE, 32'h200, 32'hA0, 3'd0);
        push(T_WRITE, 32'h210, 32'hA1, 3'd1);
        push(T_WRITE, 32'h220, 32'hA2, 3'd2);
        push(T_WRITE, 32'h230, 32'hA3, 3'd3);
        check("f_count_full", count, 4);
        check("f_cpu_ready_full", cpu_ready, 0);
        check("f_outstanding", outstanding, 4);
        cpu_valid = 1'b1;
        cpu_op    = T_WRITE;
        cpu_addr  = 32'h240;
        cpu_wdata = 32'hA4;
        tick();
        tick();
        check("f_held_ready", cpu_ready, 0);
        check("f_held_count", count, 4);
        check("f_stable_op", ctrl_op, T_WRITE);
        check("f_stable_id", ctrl_id, 0);
        check("f_stable_addr", ctrl_addr, 32'h200);
        check("f_stable_wdata", ctrl_wdata, 32'hA0);
        ctrl_ready = 1'b1;
        #1;
        check("f_no_ready_path", cpu_ready, 0);
        tick();
        ctrl_ready = 1'b0;
        check("f_pop_count", count, 3);
        check("f_pop_cpu_ready", cpu_ready, 1);
        check("f_new_head", ctrl_addr, 32'h210);
        sb.push_back({T_WRITE, 3'd4, 32'h240, 32'hA4});
        tick();
        cpu_valid = 1'b0;
        check("f_refill_count", count, 4);
        check("f_refill_outstanding", outstanding, 5);
        drain("f_drain");

        // Out-of-order completion sets the sticky error
        complete(3'd0);
        check("g_outstanding4", outstanding, 4);
        complete(3'd2);
        check("g_err_set", err_cpl, 1);
        check("g_outstanding_hold", outstanding, 4);
        tick();
        check("g_err_sticky", err_cpl, 1);
        complete(3'd1);
        check("g_oldest_kept", outstanding, 3);
        check("g_err_still", err_cpl, 1);

        // ID exhaustion and wrap
        do_reset();
        tick();
        ctrl_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(T_READ, 32'h800 + 32'(i * 4), 32'h0, 3'(i));
            if (i == 3) begin
`ifdef CACHE_REQ_QUEUE_BYPASS_EN
                check("h_stream_count", count, 0);
`else
                check("h_stream_count", count, 1);
`endif
            end
        end
        check("h_outstanding8", outstanding, 8);
        check("h_cpu_ready_ids", cpu_ready, 0);
        cpu_valid = 1'b1;
        cpu_op    = T_READ;
        cpu_addr  = 32'h900;
        cpu_wdata = 32'h0;
        cpl_valid = 1'b1;
        cpl_id    = 3'd0;
        #1;
        check("h_ninth_held", cpu_ready, 0);
        tick();
        check("h_outstanding7", outstanding, 7);
        check("h_cpu_ready_back", cpu_ready, 1);
        cpl_id = 3'd1;
        sb.push_back({T_READ, 3'd0, 32'h900, 32'h0});
        tick();
        cpl_valid = 1'b0;
        cpu_valid = 1'b0;
        check("h_issue_and_cpl", outstanding, 7);
        drain("h_drain");

        // Same-cycle presentation only in the bypass build
        do_reset();
        tick();
        ctrl_ready = 1'b1;
        cpu_valid  = 1'b1;
        cpu_op     = T_READ;
        cpu_addr   = 32'h40;
        cpu_wdata  = 32'h0;
        #1;
        check("i_cpu_ready", cpu_ready, 1);
        sb.push_back({T_READ, 3'd0, 32'h40, 32'h0});
`ifdef CACHE_REQ_QUEUE_BYPASS_EN
        check("i_same_valid", ctrl_valid, 1);
        check("i_same_addr", ctrl_addr, 32'h40);
        check("i_same_id", ctrl_id, 0);
`else
        check("i_same_valid", ctrl_valid, 0);
`endif
        tick();
        cpu_valid = 1'b0;
        #1;
`ifdef CACHE_REQ_QUEUE_BYPASS_EN
        check("i_next_count", count, 0);
        check("i_next_valid", ctrl_valid, 0);
`else
        check("i_next_count", count, 1);
        check("i_next_valid", ctrl_valid, 1);
        check("i_next_addr", ctrl_addr, 32'h40);
`endif
        tick();
        check("i_final_count", count, 0);
        check("i_outstanding", outstanding, 1);
        ctrl_ready = 1'b0;
        tick();
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_req_queue.md
CACHE_REQ_QUEUE -- requirements
Module: cache_req_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of request entries (power of two, >=2).
REQ-002 Parameter ADDRESS_WIDTH, default 32, SHALL set the request address width.
REQ-003 Parameter DATA_WIDTH, default 32, SHALL set the write-data width.
REQ-004 Parameter REQ_ID, default 3, SHALL set the request-ID width; max outstanding = 2^REQ_ID.
REQ-005 clk  in  1  SHALL be the clock; all state updates on posedge.
REQ-006 reset_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-007 cpu_valid/cpu_ready  in/out  1/1  SHALL be the CPU-side request handshake.
REQ-008 cpu_op  in  2  SHALL carry the op: 00 NO_OP, 01 READ, 10 WRITE, 11 reserved.
REQ-009 cpu_addr/cpu_wdata  in  ADDRESS_WIDTH/DATA_WIDTH  SHALL carry the request address/data.
REQ-010 ctrl_valid/ctrl_ready  out/in  1/1  SHALL be the controller-side handshake.
REQ-011 ctrl_op/ctrl_id/ctrl_addr/ctrl_wdata  out  2/REQ_ID/ADDRESS_WIDTH/DATA_WIDTH  SHALL carry the head request.
REQ-012 cpl_valid/cpl_id  in  1/REQ_ID  SHALL signal one request completion per cycle.
REQ-013 count  out  $clog2(DEPTH)+1  SHALL give the number of queued entries.
REQ-014 outstanding  out  REQ_ID+1  SHALL give the number of issued-but-uncompleted IDs.
REQ-015 err_cpl  out  1  SHALL be a sticky completion-error flag.

Function
REQ-016 cpu_ready SHALL equal (count<DEPTH) & (outstanding<2^REQ_ID), registered-state only, no path from ctrl_ready.
REQ-017 Push on cpu_valid&cpu_ready for READ/WRITE SHALL store {op,addr,wdata,next_id}, increment next_id (wrap mod 2^REQ_ID) and outstanding.
REQ-018 Accepted NO_OP and reserved ops SHALL be consumed and dropped: no entry, no ID, no counter change.
REQ-019 ctrl_valid SHALL equal (count!=0); ctrl_* SHALL show the head entry and hold stable while ctrl_valid&!ctrl_ready.
REQ-020 Pop on ctrl_valid&ctrl_ready SHALL advance the read pointer and decrement count.
REQ-021 Simultaneous push and pop SHALL leave count unchanged; when full, push is blocked even if pop occurs that cycle.
REQ-022 Push-to-ctrl_valid latency SHALL be 1 cycle (non-bypass).
REQ-023 Pointers SHALL wrap modulo DEPTH; FIFO order SHALL be preserved.
REQ-024 Completions SHALL be in order: oldest_id counter increments on each accepted cpl_valid.
REQ-025 cpl_valid with outstanding==0, or cpl_id!=oldest_id, SHALL set err_cpl and SHALL NOT change outstanding or oldest_id.
REQ-026 Simultaneous ID issue and valid completion SHALL leave outstanding unchanged.

Reset
REQ-027 Asserting reset_n low SHALL immediately clear count, pointers, next_id, oldest_id, outstanding, err_cpl; ctrl_valid=0, cpu_ready=0 while in reset, 1 the first cycle after release.
REQ-028 Reset mid-operation SHALL discard all queued entries; ctrl_* data outputs SHALL read 0.

Configuration
REQ-029 With CACHE_REQ_QUEUE_BYPASS_EN defined, a READ/WRITE arriving when count==0 and ctrl_ready==1 SHALL be presented on ctrl_* the same cycle (ID assigned), popped immediately, not stored.
REQ-030 Without CACHE_REQ_QUEUE_BYPASS_EN, all requests SHALL pass through storage with the REQ-022 latency.

Structure
REQ-031 Op encodings (NO_OP/READ/WRITE) and a packed req_entry_t {op,id,addr,wdata} SHALL live in design_params.
REQ-032 Storage SHALL be one sub-module, req_fifo_mem (DEPTH x req_entry_t, write port + async read port); ID/outstanding tracking stays in the top.

Verification
REQ-033 Reset, push READ 0x100 -> next cycle ctrl_valid=1, ctrl_id=0, ctrl_addr=0x100, count=1, outstanding=1.
REQ-034 ctrl_ready=0, push 4 WRITEs -> count=4, cpu_ready=0; 5th held; ctrl_* stable; one pop -> cpu_ready=1 next cycle.
REQ-035 Issue 8 requests without cpl -> outstanding=8, cpu_ready=0; cpl_id=0 -> outstanding=7, cpu_ready=1; 9th request gets ctrl_id=0 (wrap).
REQ-036 cpl_valid with outstanding=0, and cpl_id=2 when oldest_id=1 -> err_cpl=1 sticky, outstanding unchanged.
REQ-037 Push NO_OP -> accepted, count=0, ctrl_valid=0, next_id unchanged.
REQ-038 Bypass build: empty queue, ctrl_ready=1, push READ 0x40 -> same-cycle ctrl_valid=1, ctrl_addr=0x40, count stays 0; non-bypass build: 1-cycle delay.
